pe_row_conv: RTL and testbench
==============================

Name: pe_row_conv

Overview:
- Row-stationary processing element for the Eyeriss-style array.
- Serially loads one input-activation row (iact_size words), then one filter row (kernel_size words).
- Computes a 1-D valid convolution, one MAC per cycle, and presents iact_size-kernel_size+1 partial sums on parallel output ports.
- Sits under the array controller, which streams operands on the iact and weight buses and watches the status flags.

Parameters:
- d_width, 32, data width of operands, partial sums and outputs.
- iact_size, 5, input-activation row length.
- kernel_size, 3, filter row length. iact_size-kernel_size+1 must equal 3 (one output port per psum); other values are unsupported.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level run request.
- iact  in  d_width  activation word, one captured per cycle during LOAD_IACT.
- weight  in  d_width  filter word, one captured per cycle during LOAD_WEIGHT.
- load_iact  out  1  iact row fully loaded (sticky).
- load_weight  out  1  filter row fully loaded (sticky).
- done  out  1  all psums valid.
- pe_out0/1/2  out  d_width each  psum for output positions 0, 1, 2.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All flags are 0, all psums/outputs are 0, and the buffers and counters are cleared.
  - Reset mid-operation aborts immediately.
- IDLE: when start=1 at a clock edge, go to LOAD_IACT. At that same edge, clear psums, load_iact, load_weight and done. No data is captured on the start edge.
- LOAD_IACT:
  - Capture iact into buf[k] on each of the next iact_size edges, k=0..iact_size-1 in order.
  - After the last capture, go to IACT_DONE.
- IACT_DONE:
  - load_iact=1 from here until the next run start or reset.
  - Lasts one gap cycle with no capture, then go to LOAD_WEIGHT. This gives the producer a cycle to switch to weights.
- LOAD_WEIGHT:
  - Capture weight into w[j] on each of kernel_size edges, j=0..kernel_size-1.
  - Then go to WEIGHT_DONE.
- WEIGHT_DONE: load_weight=1, sticky like load_iact. One gap cycle, then go to COMPUTE.
- COMPUTE:
  - Nested counters: o=0..2 (outer), j=0..kernel_size-1 (inner).
  - Each cycle: psum[o] += buf[o+j]*w[j].
  - Total 3*kernel_size cycles (9 at defaults), then go to DONE.
- Arithmetic: unsigned; product and sum truncated modulo 2^d_width with no saturation.
- pe_outN is driven directly from the psum[N] register, so intermediate values are visible during COMPUTE. Consumers qualify on done.
- DONE:
  - done=1 and outputs held stable.
  - Stay while start=1. When start=0, return to IDLE; flags and outputs keep their values until the next start.
- start is ignored outside IDLE and DONE, so deasserting it mid-run does not abort.
- Latency: 1 (start) + iact_size + 1 + kernel_size + 1 + 3*kernel_size edges from the start-sampling edge until done rises. At defaults, done is high after the 20th edge counting the start edge.

Decomposition:
- Shared package pe_pkg holds:
  - the state enum (IDLE, LOAD_IACT, IACT_DONE, LOAD_WEIGHT, WEIGHT_DONE, COMPUTE, DONE);
  - the default widths/sizes;
  - NUM_OUT = iact_size-kernel_size+1.
- Optional sub-module pe_mac: combinational multiply-accumulate, acc + a*b truncated to d_width.
- FSM, buffers and counters stay in pe_row_conv.

Test Plan:
- Nominal run:
  - start=1 held; iact 2,4,6,8,10 on consecutive capture cycles; after load_iact rises, weights 1,2,3 after the gap cycle.
  - Expect load_iact, then load_weight, then done, with pe_out0=28, pe_out1=40, pe_out2=52.
- Restart: after done, drop start, then rerun with iact 1,1,1,1,1 and weights 5,5,5. Expect flags cleared on the restart edge and outputs 15,15,15.
- Reset mid-COMPUTE: pull rst_n low mid-compute. Expect immediate return to IDLE, all outputs and flags 0, and a subsequent clean run yielding 28/40/52.
- Overflow: iact all 0xFFFFFFFF, weights 1,1,1 (d_width=32). Expect every output 0xFFFFFFFD (modulo wrap).
- Hold in DONE: keep start=1 for 10 cycles after done. Expect done to stay 1, outputs unchanged, and no restart. Drop start and expect IDLE with done kept at 1 until the next start.
- Gap-cycle check: drive a nonzero weight during the IACT_DONE cycle. Expect it not to be captured, so results are unchanged vs the nominal run.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and default sizing for the row-stationary processing element.
package pe_pkg;

  localparam int D_WIDTH     = 32;
  localparam int IACT_SIZE   = 5;
  localparam int KERNEL_SIZE = 3;
  localparam int NUM_OUT     = IACT_SIZE - KERNEL_SIZE + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IACT,
    IACT_DONE,
    LOAD_WEIGHT,
    WEIGHT_DONE,
    COMPUTE,
    DONE
  } state_t;

  // Index width for an n-entry array, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate, wrapping modulo 2^d_width.
module pe_mac #(
  parameter int d_width = 32
) (
  input  logic [d_width-1:0] acc,
  input  logic [d_width-1:0] a,
  input  logic [d_width-1:0] b,
  output logic [d_width-1:0] sum
);

  logic [d_width-1:0] prod;

  assign prod = a * b;
  assign sum  = acc + prod;

endmodule

// File: rtl/pe_row_conv.sv
// Row-stationary PE: serially loads an activation row and a filter row, then
// runs a 1-D valid convolution one MAC per cycle into parallel psum registers.
//
// state       | meaning
// IDLE        | waiting for start; flags and outputs hold last run
// LOAD_IACT   | capture one activation word per cycle
// IACT_DONE   | one gap cycle so the producer can switch to weights
// LOAD_WEIGHT | capture one filter word per cycle
// WEIGHT_DONE | one gap cycle before compute
// COMPUTE     | psum[o] += iact[o+j] * w[j], j inner, o outer
// DONE        | results stable; leave once start drops
module pe_row_conv
  import pe_pkg::*;
#(
  parameter int d_width     = D_WIDTH,
  parameter int iact_size   = IACT_SIZE,
  parameter int kernel_size = KERNEL_SIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [d_width-1:0] iact,
  input  logic [d_width-1:0] weight,
  output logic               load_iact,
  output logic               load_weight,
  output logic               done,
  output logic [d_width-1:0] pe_out0,
  output logic [d_width-1:0] pe_out1,
  output logic [d_width-1:0] pe_out2
);

  localparam int num_out = iact_size - kernel_size + 1;
  localparam int kw      = idx_width(iact_size);
  localparam int jw      = idx_width(kernel_size);
  localparam int ow      = idx_width(num_out);

  state_t state, state_nxt;

  logic [d_width-1:0] iact_buf [iact_size];
  logic [d_width-1:0] w_buf    [kernel_size];
  logic [d_width-1:0] psum     [num_out];

  logic [kw-1:0] k_cnt;
  logic [jw-1:0] j_cnt;
  logic [ow-1:0] o_cnt;
  logic [kw-1:0] tap;
  logic          k_last, j_last, o_last;
  logic [d_width-1:0] mac_sum;

  assign k_last = (k_cnt == kw'(iact_size - 1));
  assign j_last = (j_cnt == jw'(kernel_size - 1));
  assign o_last = (o_cnt == ow'(num_out - 1));
  assign tap    = kw'(o_cnt) + kw'(j_cnt);

  pe_mac #(.d_width(d_width)) u_mac (
    .acc (psum[o_cnt]),
    .a   (iact_buf[tap]),
    .b   (w_buf[j_cnt]),
    .sum (mac_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:        if (start) state_nxt = LOAD_IACT;
      LOAD_IACT:   if (k_last) state_nxt = IACT_DONE;
      IACT_DONE:   state_nxt = LOAD_WEIGHT;
      LOAD_WEIGHT: if (j_last) state_nxt = WEIGHT_DONE;
      WEIGHT_DONE: state_nxt = COMPUTE;
      COMPUTE:     if (o_last && j_last) state_nxt = DONE;
      DONE:        if (!start) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // j_cnt doubles as the weight-load index and the inner compute index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_iact   <= 1'b0;
      load_weight <= 1'b0;
      done        <= 1'b0;
      k_cnt       <= '0;
      j_cnt       <= '0;
      o_cnt       <= '0;
      for (int i = 0; i < iact_size; i++)   iact_buf[i] <= '0;
      for (int i = 0; i < kernel_size; i++) w_buf[i]    <= '0;
      for (int i = 0; i < num_out; i++)     psum[i]     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            load_iact   <= 1'b0;
            load_weight <= 1'b0;
            done        <= 1'b0;
            k_cnt       <= '0;
            j_cnt       <= '0;
            o_cnt       <= '0;
            for (int i = 0; i < num_out; i++) psum[i] <= '0;
          end
        end
        LOAD_IACT: begin
          iact_buf[k_cnt] <= iact;
          if (k_last) begin
            k_cnt     <= '0;
            load_iact <= 1'b1;
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end
        LOAD_WEIGHT: begin
          w_buf[j_cnt] <= weight;
          if (j_last) begin
            j_cnt       <= '0;
            load_weight <= 1'b1;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end
        COMPUTE: begin
          psum[o_cnt] <= mac_sum;
          if (j_last) begin
            j_cnt <= '0;
            if (o_last) begin
              o_cnt <= '0;
              done  <= 1'b1;
            end else begin
              o_cnt <= o_cnt + 1'b1;
            end
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pe_out0 = psum[0];
  assign pe_out1 = psum[1];
  assign pe_out2 = psum[2];

endmodule

// File: tb/tb_pe_row_conv.sv
// Self-checking bench for pe_row_conv: directed vector table, corner-case
// sequences and randomized runs against a plain-arithmetic convolution model.
module tb_pe_row_conv;
  import pe_pkg::*;

  localparam int DW = 32;

  typedef logic [4:0][DW-1:0] row_t;
  typedef logic [2:0][DW-1:0] ker_t;

  typedef struct {
    row_t          a;
    ker_t          w;
    logic [DW-1:0] gapw;
    ker_t          e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] iact, weight;
  logic          load_iact, load_weight, done;
  logic [DW-1:0] pe_out0, pe_out1, pe_out2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_row_conv #(.d_width(DW), .iact_size(5), .kernel_size(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .iact        (iact),
    .weight      (weight),
    .load_iact   (load_iact),
    .load_weight (load_weight),
    .done        (done),
    .pe_out0     (pe_out0),
    .pe_out1     (pe_out1),
    .pe_out2     (pe_out2)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input ker_t e);
    chk({tag, "_out0"}, pe_out0, e[0]);
    chk({tag, "_out1"}, pe_out1, e[1]);
    chk({tag, "_out2"}, pe_out2, e[2]);
  endtask

  // Valid 1-D convolution, every sum wrapping modulo 2^DW.
  function automatic ker_t ref_conv(input row_t a, input ker_t w);
    ker_t r;
    for (int o = 0; o < 3; o++) begin
      logic [DW-1:0] s;
      s = '0;
      for (int j = 0; j < 3; j++) s = s + a[o+j] * w[j];
      r[o] = s;
    end
    return r;
  endfunction

  // Load phase: start edge, 5 iact captures, gap, 3 weight captures, gap.
  task automatic load_run(input row_t a, input ker_t w, input logic [DW-1:0] gapw,
                          input bit drop_start);
    start  = 1'b0;
    weight = gapw;
    repeat (2) @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("clr_load_iact", {31'b0, load_iact}, 32'd0);
        chk("clr_load_weight", {31'b0, load_weight}, 32'd0);
        chk("clr_done", {31'b0, done}, 32'd0);
        chk_outs("clr", '0);
        if (drop_start) start = 1'b0;
      end
      iact = a[k];
    end
    @(negedge clk);
    chk("load_iact_set", {31'b0, load_iact}, 32'd1);
    chk("load_weight_early", {31'b0, load_weight}, 32'd0);
    iact = 32'hDEAD_BEEF;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      weight = w[j];
    end
    @(negedge clk);
    chk("load_weight_set", {31'b0, load_weight}, 32'd1);
    chk("done_early", {31'b0, done}, 32'd0);
    weight = gapw;
  endtask

  task automatic run(input row_t a, input ker_t w, input logic [DW-1:0] gapw,
                     input bit drop_start);
    int n;
    load_run(a, w, gapw, drop_start);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", DW'(n), 32'd10);
  endtask

  vec_t vecs[6];
  row_t ra;
  ker_t rw, re;

  initial begin
    vecs[0] = '{a: {32'd10, 32'd8, 32'd6, 32'd4, 32'd2}, w: {32'd3, 32'd2, 32'd1},
                gapw: 32'd0, e: {32'd52, 32'd40, 32'd28}};
    vecs[1] = '{a: {32'd1, 32'd1, 32'd1, 32'd1, 32'd1}, w: {32'd5, 32'd5, 32'd5},
                gapw: 32'd0, e: {32'd15, 32'd15, 32'd15}};
    vecs[2] = '{a: {5{32'hFFFF_FFFF}}, w: {32'd1, 32'd1, 32'd1},
                gapw: 32'd0, e: {3{32'hFFFF_FFFD}}};
    vecs[3] = '{a: {32'd10, 32'd8, 32'd6, 32'd4, 32'd2}, w: {32'd3, 32'd2, 32'd1},
                gapw: 32'h77, e: {32'd52, 32'd40, 32'd28}};
    vecs[4] = '{a: {32'd2, 32'd0, 32'd1, 32'd0, 32'd3}, w: {32'd1, 32'd0, 32'd2},
                gapw: 32'h5, e: {32'd4, 32'd0, 32'd7}};
    vecs[5] = '{a: {5{32'h0001_0000}}, w: {32'd0, 32'd1, 32'h0001_0000},
                gapw: 32'd9, e: {3{32'h0001_0000}}};

    rst_n  = 1'b0;
    start  = 1'b0;
    iact   = '0;
    weight = '0;
    #12;
    chk("rst_load_iact", {31'b0, load_iact}, 32'd0);
    chk("rst_load_weight", {31'b0, load_weight}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk_outs("rst", '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run(vecs[v].a, vecs[v].w, vecs[v].gapw, 1'b0);
      chk_outs($sformatf("vec%0d", v), vecs[v].e);
    end

    // Hold in DONE with start high: no restart, results stable.
    run(vecs[0].a, vecs[0].w, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_done", {31'b0, done}, 32'd1);
      chk("hold_load_iact", {31'b0, load_iact}, 32'd1);
      chk_outs("hold", vecs[0].e);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_done_kept", {31'b0, done}, 32'd1);
    chk_outs("idle_kept", vecs[0].e);

    // Reset partway through COMPUTE aborts immediately.
    load_run(vecs[4].a, vecs[4].w, 32'd0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_load_iact", {31'b0, load_iact}, 32'd0);
    chk("midrst_load_weight", {31'b0, load_weight}, 32'd0);
    chk_outs("midrst", '0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(vecs[0].a, vecs[0].w, 32'd0, 1'b0);
    chk_outs("after_rst", vecs[0].e);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 5; k++) ra[k] = (r < 4) ? DW'($urandom_range(0, 255)) : $urandom();
      for (int j = 0; j < 3; j++) rw[j] = (r < 4) ? DW'($urandom_range(0, 255)) : $urandom();
      re = ref_conv(ra, rw);
      run(ra, rw, $urandom(), r == 2);
      chk_outs($sformatf("rand%0d", r), re);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
